// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries decode control, operands and immediate into EX,
// with stall (hold), flush (bubble) and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_A_W  = 5,
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic                ValidD,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                MemWriteD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic                ALUSrcD,
  input  logic                RegDstD,
  input  logic [DATA_W-1:0]   RD1D,
  input  logic [DATA_W-1:0]   RD2D,
  input  logic [REG_A_W-1:0]  RsD,
  input  logic [REG_A_W-1:0]  RtD,
  input  logic [REG_A_W-1:0]  RdD,
  input  logic [DATA_W-1:0]   SignImmD,
  output logic                ValidE,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                ALUSrcE,
  output logic                RegDstE,
  output logic [DATA_W-1:0]   RD1E,
  output logic [DATA_W-1:0]   RD2E,
  output logic [REG_A_W-1:0]  RsE,
  output logic [REG_A_W-1:0]  RtE,
  output logic [REG_A_W-1:0]  RdE,
  output logic [DATA_W-1:0]   SignImmE,
  output logic [CNT_W-1:0]    BubbleCnt
);

  // Flush outranks stall: a simultaneous request yields a bubble, not a hold.
  always_ff @(posedge clk) begin
    if (!rst_n || FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      SignImmE    <= '0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      RegWriteE   <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      MemWriteE   <= MemWriteD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      RegDstE     <= RegDstD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      SignImmE    <= SignImmD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BubbleCnt <= '0;
    end else if (FlushE && (BubbleCnt != '1)) begin
      BubbleCnt <= BubbleCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg: a slot-level reference model plus directed literal checks,
// run on a default-width instance and a 4-bit-counter instance sharing the same inputs.
module tb_id_ex_stage_reg;

  localparam int unsigned BW = 1+1+1+1+3+1+1+32+32+5+5+5+32;

  logic        clk = 1'b0;
  logic        rst_n, StallE, FlushE;
  logic        ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;

  logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;
  logic [15:0] BubbleCnt;

  logic        b_ValidE, b_RegWriteE, b_MemtoRegE, b_MemWriteE, b_ALUSrcE, b_RegDstE;
  logic [2:0]  b_ALUControlE;
  logic [31:0] b_RD1E, b_RD2E, b_SignImmE;
  logic [4:0]  b_RsE, b_RtE, b_RdE;
  logic [3:0]  b_BubbleCnt;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [BW-1:0] exp_slot;
  int            exp_cnt, exp_cnt4;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .BubbleCnt(BubbleCnt)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .ValidE(b_ValidE), .RegWriteE(b_RegWriteE), .MemtoRegE(b_MemtoRegE), .MemWriteE(b_MemWriteE),
    .ALUControlE(b_ALUControlE), .ALUSrcE(b_ALUSrcE), .RegDstE(b_RegDstE),
    .RD1E(b_RD1E), .RD2E(b_RD2E), .RsE(b_RsE), .RtE(b_RtE), .RdE(b_RdE), .SignImmE(b_SignImmE),
    .BubbleCnt(b_BubbleCnt)
  );

  function automatic logic [BW-1:0] in_slot();
    return {ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD, RegDstD,
            RD1D, RD2D, RsD, RtD, RdD, SignImmD};
  endfunction

  function automatic logic [BW-1:0] out_slot();
    return {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
            RD1E, RD2E, RsE, RtE, RdE, SignImmE};
  endfunction

  function automatic logic [BW-1:0] out_slot4();
    return {b_ValidE, b_RegWriteE, b_MemtoRegE, b_MemWriteE, b_ALUControlE, b_ALUSrcE, b_RegDstE,
            b_RD1E, b_RD2E, b_RsE, b_RtE, b_RdE, b_SignImmE};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the E slot is the last D slot accepted; a flush or reset empties it.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_slot = '0;
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end else if (FlushE) begin
      exp_slot = '0;
      exp_cnt  = (exp_cnt  < 65535) ? exp_cnt  + 1 : 65535;
      exp_cnt4 = (exp_cnt4 < 15)    ? exp_cnt4 + 1 : 15;
    end else if (!StallE) begin
      exp_slot = in_slot();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("slot", out_slot(), exp_slot);
      check("slot_cnt4", out_slot4(), exp_slot);
      check("bubblecnt", BW'(BubbleCnt), BW'(exp_cnt));
      check("bubblecnt4", BW'(b_BubbleCnt), BW'(exp_cnt4));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    {ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD} = 6'($urandom);
    ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    rand_inputs();
    {ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD} = '1;
    ALUControlD = 3'd5; RD1D |= 32'd1; RD2D |= 32'd1; SignImmD |= 32'd1;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd3;
    step();
    check_en = 1'b1;
    step();
    check("reset_slot", out_slot(), '0);
    check("reset_cnt", BW'(BubbleCnt), '0);

    rst_n = 1'b1;
    rand_inputs();
    RD1D = 32'h0000_1234; SignImmD = 32'hFFFF_FF80; RtD = 5'd9; ALUSrcD = 1'b1; ValidD = 1'b1;
    step();
    check("load_signimm", BW'(SignImmE), BW'(32'hFFFF_FF80));
    check("load_rd1", BW'(RD1E), BW'(32'h0000_1234));
    check("load_rt_alusrc_valid", BW'({RtE, ALUSrcE, ValidE}), BW'({5'd9, 1'b1, 1'b1}));

    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      check("stall_signimm", BW'(SignImmE), BW'(32'hFFFF_FF80));
      check("stall_rd1_rt", BW'({RD1E, RtE}), BW'({32'h0000_1234, 5'd9}));
    end
    StallE = 1'b0;
    RD1D = 32'hCAFE_0001; ValidD = 1'b1;
    step();
    check("release_rd1", BW'({RD1E, ValidE}), BW'({32'hCAFE_0001, 1'b1}));

    RegWriteD = 1'b1; MemWriteD = 1'b1; ValidD = 1'b1; FlushE = 1'b1; StallE = 1'b1;
    step();
    check("flush_ctrl", BW'({RegWriteE, MemWriteE, ValidE}), '0);
    check("flush_signimm", BW'(SignImmE), '0);
    check("flush_cnt", BW'(BubbleCnt), BW'(16'd1));
    StallE = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      rand_inputs();
      step();
      if (i == 15) check("sat_reach", BW'(b_BubbleCnt), BW'(4'hF));
    end
    check("sat_hold", BW'(b_BubbleCnt), BW'(4'hF));
    check("cnt16_after20", BW'(BubbleCnt), BW'(16'd20));

    FlushE = 1'b0;
    rand_inputs();
    step();
    StallE = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check("midreset_slot", out_slot(), '0);
    check("midreset_cnt", BW'({BubbleCnt, b_BubbleCnt}), '0);
    rst_n = 1'b1; StallE = 1'b0;
    rand_inputs();
    RD2D = 32'h5A5A_5A5A; ValidD = 1'b1;
    step();
    check("post_reset_load", BW'({RD2E, ValidE}), BW'({32'h5A5A_5A5A, 1'b1}));

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      FlushE = ($urandom_range(0, 9) == 0);
      StallE = ($urandom_range(0, 4) == 0);
      rst_n  = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1; FlushE = 1'b1; StallE = 1'b0;
    for (int i = 0; i < 70; i++) step();
    FlushE = 1'b0;
    step();

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
